load_result_buffer_mp: RTL and testbench

// - Multi-port successor of the single-port load result buffer, between the load pipeline/memory controller and the result buses.
// - Holds loads whose data is not yet deliverable, captures cache-line data forwarded by the memory controller, and writes back up to NUM_OUT loads per cycle.
// - Selection is oldest-first by sqN. Incoming loads bypass the buffer when they win selection.
// - New versus the single-port generation: NUM_IN enqueue ports, NUM_OUT writeback ports, per-port stall, XLEN 32/64 with doubleword loads.

---
 rtl/load_result_buffer_mp_pkg.sv | 65 ++++++
 rtl/load_result_buffer_mp_if.sv | 24 ++
 rtl/load_result_buffer_mp_oldest_sel.sv | 59 +++++
 rtl/load_result_buffer_mp.sv | 169 ++++++++++++++++
 tb/tb_load_result_buffer_mp.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_result_buffer_mp_pkg.sv
// Shared types for the multi-port load result buffer: load/result uops, branch flush,
// memory-controller line forwarding, and wrap-safe sqN ordering.
package load_result_buffer_mp_pkg;

  localparam int unsigned AXI_WIDTH = 128;
  localparam int unsigned MAX_XLEN  = 64;
  localparam int unsigned SQN_W     = 8;
  localparam int unsigned TAG_W     = 7;

  typedef enum logic [1:0] {
    AGU_NONE, AGU_ADDR_MISALIGN, AGU_ACCESS_FAULT, AGU_PAGE_FAULT
  } agu_exc_t;

  typedef enum logic [1:0] {
    FLAGS_NONE, FLAGS_LD_MA, FLAGS_LD_AF, FLAGS_LD_PF
  } flags_t;

  // data holds the naturally aligned XLEN word containing addr
  typedef struct packed {
    logic [MAX_XLEN-1:0]   data;
    logic [31:0]           addr;
    logic [1:0]            size;
    logic                  sext;
    logic [MAX_XLEN/8-1:0] fwd_mask;
    logic [TAG_W-1:0]      tag_dst;
    logic [SQN_W-1:0]      sqn;
    logic                  do_not_commit;
    logic                  external;
    agu_exc_t              exc;
    logic                  data_avail;
    logic                  valid;
  } load_res_uop_t;

  typedef struct packed {
    logic [MAX_XLEN-1:0] result;
    logic [TAG_W-1:0]    tag_dst;
    logic [SQN_W-1:0]    sqn;
    flags_t              flags;
    logic                do_not_commit;
    logic                valid;
  } res_uop_t;

  typedef struct packed {
    logic             taken;
    logic [SQN_W-1:0] sqn;
  } branch_prov_t;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          addr;
    logic [AXI_WIDTH-1:0] data;
  } ld_data_fwd_t;

  typedef struct packed {
    ld_data_fwd_t ld_data_fwd;
  } memc_res_t;

  // a is strictly younger than b; correct across sqN wrap
  function automatic logic sqn_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

endpackage

// File: rtl/load_result_buffer_mp_if.sv
// Load pipeline / memory controller / result bus bundle for the load result buffer.
interface load_result_buffer_mp_if
  import load_result_buffer_mp_pkg::*;
#(
  parameter int unsigned NUM_IN  = 2,
  parameter int unsigned NUM_OUT = 2
);
  branch_prov_t                  branch;
  memc_res_t                     memc;
  load_res_uop_t [NUM_IN-1:0]    enq_uop;
  logic                          ready;
  logic [NUM_OUT-1:0]            stall;
  res_uop_t [NUM_OUT-1:0]        wb_uop;

  modport master (
    output branch, memc, enq_uop, stall,
    input  ready, wb_uop
  );

  modport slave (
    input  branch, memc, enq_uop, stall,
    output ready, wb_uop
  );
endinterface

// File: rtl/load_result_buffer_mp_oldest_sel.sv
// Balanced compare tree picking the best unmasked request: non-external first, then oldest
// sqN; ties resolve to the lower index.
module lrb_oldest_sel
  import load_result_buffer_mp_pkg::*;
#(
  parameter int unsigned N = 6,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            ext,
  input  logic [N-1:0][SQN_W-1:0] sqn,
  input  logic [N-1:0]            mask,
  output logic                    valid,
  output logic [IdxW-1:0]         idx
);
  localparam int unsigned P     = 1 << IdxW;
  localparam int unsigned Nodes = 2 * P - 1;

  logic             n_valid [Nodes];
  logic             n_ext   [Nodes];
  logic [SQN_W-1:0] n_sqn   [Nodes];
  logic [IdxW-1:0]  n_idx   [Nodes];

  // Heap layout: leaf i sits at P-1+i, so every left child covers lower indices.
  always_comb begin
    logic take_r;
    int   l;
    int   r;
    take_r = 1'b0;
    l = 0;
    r = 0;
    for (int i = 0; i < int'(Nodes); i++) begin
      n_valid[i] = 1'b0;
      n_ext[i]   = 1'b0;
      n_sqn[i]   = '0;
      n_idx[i]   = '0;
    end
    for (int i = 0; i < int'(N); i++) begin
      n_valid[int'(P) - 1 + i] = req[i] && !mask[i];
      n_ext[int'(P) - 1 + i]   = ext[i];
      n_sqn[int'(P) - 1 + i]   = sqn[i];
      n_idx[int'(P) - 1 + i]   = IdxW'(i);
    end
    for (int n = int'(P) - 2; n >= 0; n--) begin
      l = 2 * n + 1;
      r = 2 * n + 2;
      take_r = n_valid[r] && (!n_valid[l] || (n_ext[l] && !n_ext[r]) ||
               (!n_ext[l] && !n_ext[r] && sqn_younger(n_sqn[l], n_sqn[r])));
      n_valid[n] = take_r ? n_valid[r] : n_valid[l];
      n_ext[n]   = take_r ? n_ext[r]   : n_ext[l];
      n_sqn[n]   = take_r ? n_sqn[r]   : n_sqn[l];
      n_idx[n]   = take_r ? n_idx[r]   : n_idx[l];
    end
  end

  assign valid = n_valid[0];
  assign idx   = n_idx[0];

endmodule

// File: rtl/load_result_buffer_mp.sv
// Multi-port load result buffer: parks loads until data is available, captures forwarded
// cache lines, and writes back up to NUM_OUT loads per cycle oldest-first with bypass.
module load_result_buffer_mp
  import load_result_buffer_mp_pkg::*;
#(
  parameter int unsigned SIZE    = 4,
  parameter int unsigned NUM_IN  = 2,
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned XLEN    = 32
) (
  input logic                    clk,
  input logic                    rst,
  load_result_buffer_mp_if.slave bus
);
  localparam int unsigned NC      = SIZE + NUM_IN;
  localparam int unsigned IdxW    = $clog2(NC);
  localparam int unsigned XBytes  = XLEN / 8;
  localparam int unsigned LineOff = $clog2(AXI_WIDTH / 8);

  load_res_uop_t [SIZE-1:0]     buf_q, buf_d;
  load_res_uop_t [NC-1:0]       cand;
  logic [NC-1:0]                req, ext, issued;
  logic [NC-1:0][SQN_W-1:0]     sqn;
  logic [NUM_OUT-1:0]           pick_valid;
  logic [NUM_OUT-1:0][IdxW-1:0] pick_idx;
  ld_data_fwd_t                 fwd;
  logic                         unused_fwd_lo;

  assign fwd           = bus.memc.ld_data_fwd;
  assign unused_fwd_lo = ^fwd.addr[LineOff-1:0];

  function automatic logic flushed(input load_res_uop_t u, input branch_prov_t b);
    return b.taken && !u.external && sqn_younger(u.sqn, b.sqn);
  endfunction

  function automatic load_res_uop_t apply_fwd(input load_res_uop_t u, input ld_data_fwd_t f);
    load_res_uop_t r;
    int unsigned   base;
    r    = u;
    base = (32'(u.addr[LineOff-1:0]) / XBytes) * XBytes;
    if (f.valid && u.valid && !u.data_avail && u.addr[31:LineOff] == f.addr[31:LineOff]) begin
      for (int k = 0; k < int'(XBytes); k++) begin
        if (!u.fwd_mask[k]) r.data[8*k +: 8] = f.data[8*(int'(base) + k) +: 8];
      end
      r.data_avail = 1'b1;
    end
    return r;
  endfunction

  function automatic res_uop_t fmt_result(input load_res_uop_t u);
    res_uop_t            r;
    logic [2:0]          off;
    logic [MAX_XLEN-1:0] sh;
    logic [MAX_XLEN-1:0] v;
    off = u.addr[2:0] & 3'(XBytes - 1);
    sh  = u.data >> {off, 3'b000};
    case (u.size)
      2'd0:    v = {{56{u.sext & sh[7]}}, sh[7:0]};
      2'd1:    v = {{48{u.sext & sh[15]}}, sh[15:0]};
      2'd2:    v = {{32{u.sext & sh[31]}}, sh[31:0]};
      default: v = sh;
    endcase
    v = v & ({MAX_XLEN{1'b1}} >> (MAX_XLEN - XLEN));
    r               = '0;
    r.result        = v;
    r.tag_dst       = u.tag_dst;
    r.sqn           = u.sqn;
    r.do_not_commit = u.do_not_commit;
    r.valid         = 1'b1;
    unique case (u.exc)
      AGU_NONE:          r.flags = FLAGS_NONE;
      AGU_ADDR_MISALIGN: r.flags = FLAGS_LD_MA;
      AGU_ACCESS_FAULT:  r.flags = FLAGS_LD_AF;
      default:           r.flags = FLAGS_LD_PF;
    endcase
    return r;
  endfunction

  // Buffer entries come first so equal-priority ties favour them.
  always_comb begin
    for (int i = 0; i < int'(SIZE); i++) cand[i] = buf_q[i];
    for (int p = 0; p < int'(NUM_IN); p++) cand[int'(SIZE) + p] = bus.enq_uop[p];
    for (int c = 0; c < int'(NC); c++) begin
      req[c] = cand[c].valid && cand[c].data_avail && !flushed(cand[c], bus.branch);
      ext[c] = cand[c].external;
      sqn[c] = cand[c].sqn;
    end
  end

  for (genvar j = 0; j < int'(NUM_OUT); j++) begin : g_port
    logic [NC-1:0]   mask_in, mask_out;
    logic            sel_valid;
    logic [IdxW-1:0] sel_idx;

    if (j == 0) begin : g_first
      assign mask_in = '0;
    end else begin : g_next
      assign mask_in = g_port[j-1].mask_out;
    end

    lrb_oldest_sel #(
      .N (NC)
    ) u_sel (
      .req   (req),
      .ext   (ext),
      .sqn   (sqn),
      .mask  (mask_in),
      .valid (sel_valid),
      .idx   (sel_idx)
    );

    // A stalled port neither issues nor consumes a candidate.
    assign pick_valid[j] = sel_valid && !bus.stall[j] && !rst;
    assign pick_idx[j]   = sel_idx;
    assign mask_out      = mask_in | ({{(NC-1){1'b0}}, pick_valid[j]} << sel_idx);
  end

  always_comb begin
    issued = '0;
    for (int j = 0; j < int'(NUM_OUT); j++) begin
      bus.wb_uop[j] = '0;
      if (pick_valid[j]) begin
        bus.wb_uop[j]        = fmt_result(cand[pick_idx[j]]);
        issued[pick_idx[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    int unsigned free_cnt;
    free_cnt = 0;
    for (int i = 0; i < int'(SIZE); i++) free_cnt += 32'(!buf_q[i].valid);
    bus.ready = !rst && (free_cnt >= NUM_IN);
  end

  // Enqueue only into slots free at cycle start; same-cycle dequeues free up next cycle.
  always_comb begin
    logic [SIZE-1:0] taken;
    load_res_uop_t   u;
    logic            placed;
    buf_d  = buf_q;
    taken  = '0;
    u      = '0;
    placed = 1'b0;
    for (int i = 0; i < int'(SIZE); i++) begin
      if (issued[i] || flushed(buf_q[i], bus.branch)) buf_d[i].valid = 1'b0;
      else buf_d[i] = apply_fwd(buf_q[i], fwd);
    end
    for (int p = 0; p < int'(NUM_IN); p++) begin
      u      = bus.enq_uop[p];
      placed = 1'b0;
      if (u.valid && !issued[int'(SIZE) + p] && !flushed(u, bus.branch)) begin
        for (int i = 0; i < int'(SIZE); i++) begin
          if (!placed && !buf_q[i].valid && !taken[i]) begin
            buf_d[i] = apply_fwd(u, fwd);
            taken[i] = 1'b1;
            placed   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end

endmodule

// File: tb/tb_load_result_buffer_mp.sv
// Directed self-checking bench for load_result_buffer_mp (XLEN=32 and XLEN=64 instances).
module tb_load_result_buffer_mp;
  import load_result_buffer_mp_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  load_result_buffer_mp_if #(.NUM_IN(2), .NUM_OUT(2)) ifa ();
  load_result_buffer_mp_if #(.NUM_IN(2), .NUM_OUT(2)) ifb ();

  load_result_buffer_mp #(
    .SIZE(4), .NUM_IN(2), .NUM_OUT(2), .XLEN(32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  load_result_buffer_mp #(
    .SIZE(4), .NUM_IN(2), .NUM_OUT(2), .XLEN(64)
  ) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.enq_uop = '0;
    ifa.stall   = '0;
    ifa.branch  = '0;
    ifa.memc    = '0;
    ifb.enq_uop = '0;
    ifb.stall   = '0;
    ifb.branch  = '0;
    ifb.memc    = '0;
  endtask

  function automatic load_res_uop_t mk(input logic [7:0] sq, input logic avail, input logic ex,
                                       input logic [31:0] addr, input logic [63:0] data,
                                       input logic [1:0] size, input logic sext);
    load_res_uop_t u;
    u            = '0;
    u.valid      = 1'b1;
    u.sqn        = sq;
    u.tag_dst    = sq[6:0];
    u.data_avail = avail;
    u.external   = ex;
    u.addr       = addr;
    u.data       = data;
    u.size       = size;
    u.sext       = sext;
    u.exc        = AGU_NONE;
    return u;
  endfunction

  initial begin
    load_res_uop_t u;
    logic [127:0]  line;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) line[8*i +: 8] = 8'h10 + 8'(i);

    // Reset held with valid loads offered
    idle();
    rst = 1'b1;
    ifa.enq_uop[0] = mk(8'd1, 1'b1, 1'b0, 32'h100, 64'h11, 2'd2, 1'b0);
    ifa.enq_uop[1] = mk(8'd2, 1'b1, 1'b0, 32'h104, 64'h22, 2'd2, 1'b0);
    repeat (3) begin
      #1;
      chk("rst_ready", 64'(ifa.ready), 64'd0);
      chk("rst_wb_valid", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_ready", 64'(ifa.ready), 64'd1);
    chk("post_rst_empty", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);
    tick();

    // Bypass, byte sign-extended and half zero-extended
    ifa.enq_uop[0] = mk(8'd5, 1'b1, 1'b0, 32'h1001, 64'h0000_8000, 2'd0, 1'b1);
    ifa.enq_uop[1] = mk(8'd6, 1'b1, 1'b0, 32'h1002, 64'h8001_0000, 2'd1, 1'b0);
    #1;
    chk("byp_v0", 64'(ifa.wb_uop[0].valid), 64'd1);
    chk("byp_res0", ifa.wb_uop[0].result, 64'hFFFF_FF80);
    chk("byp_sqn0", 64'(ifa.wb_uop[0].sqn), 64'd5);
    chk("byp_res1", ifa.wb_uop[1].result, 64'h0000_8001);
    chk("byp_tag1", 64'(ifa.wb_uop[1].tag_dst), 64'd6);
    tick();
    idle();
    #1;
    chk("byp_empty", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);
    tick();

    // Ordering with a stalled port
    ifa.enq_uop[0] = mk(8'd7, 1'b1, 1'b0, 32'h0, 64'h7, 2'd2, 1'b0);
    ifa.enq_uop[1] = mk(8'd3, 1'b1, 1'b0, 32'h0, 64'h3, 2'd2, 1'b0);
    ifa.stall      = 2'b11;
    #1;
    chk("ord_stalled", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);
    tick();
    idle();
    ifa.enq_uop[0] = mk(8'd9, 1'b1, 1'b0, 32'h0, 64'h9, 2'd2, 1'b0);
    ifa.stall      = 2'b01;
    #1;
    chk("ord_p0_idle", 64'(ifa.wb_uop[0].valid), 64'd0);
    chk("ord_p1_sqn3", {55'd0, ifa.wb_uop[1].valid, ifa.wb_uop[1].sqn}, {55'd0, 1'b1, 8'd3});
    tick();
    idle();
    #1;
    chk("ord_p0_sqn7", {55'd0, ifa.wb_uop[0].valid, ifa.wb_uop[0].sqn}, {55'd0, 1'b1, 8'd7});
    chk("ord_p1_sqn9", {55'd0, ifa.wb_uop[1].valid, ifa.wb_uop[1].sqn}, {55'd0, 1'b1, 8'd9});
    tick();
    #1;
    chk("ord_empty", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);

    // Flush: 10 external survives, 12/14 dropped
    ifa.enq_uop[0] = mk(8'd10, 1'b0, 1'b1, 32'h2000, 64'h0, 2'd2, 1'b0);
    ifa.enq_uop[1] = mk(8'd12, 1'b0, 1'b0, 32'h2004, 64'h0, 2'd2, 1'b0);
    tick();
    idle();
    ifa.enq_uop[0] = mk(8'd14, 1'b0, 1'b0, 32'h2008, 64'h0, 2'd2, 1'b0);
    tick();
    idle();
    #1;
    chk("flush_pre_ready", 64'(ifa.ready), 64'd0);
    ifa.branch = '{taken: 1'b1, sqn: 8'd11};
    tick();
    idle();
    #1;
    chk("flush_ready", 64'(ifa.ready), 64'd1);
    ifa.enq_uop[0] = mk(8'd11, 1'b0, 1'b0, 32'h200C, 64'h0, 2'd2, 1'b0);
    tick();
    idle();
    ifa.memc.ld_data_fwd = '{valid: 1'b1, addr: 32'h2000, data: line};
    tick();
    idle();
    #1;
    chk("flush_p0_sqn11", {55'd0, ifa.wb_uop[0].valid, ifa.wb_uop[0].sqn}, {55'd0, 1'b1, 8'd11});
    chk("flush_p1_ext10", {55'd0, ifa.wb_uop[1].valid, ifa.wb_uop[1].sqn}, {55'd0, 1'b1, 8'd10});
    chk("flush_res11", ifa.wb_uop[0].result, 64'h1F1E_1D1C);
    tick();
    #1;
    chk("flush_empty", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);

    // sqN wrap: 0xFF older than 0x01; branch 0xFF flushes 0x01 but not 0xFE
    ifa.enq_uop[0] = mk(8'h01, 1'b1, 1'b0, 32'h0, 64'h1, 2'd2, 1'b0);
    ifa.enq_uop[1] = mk(8'hFF, 1'b1, 1'b0, 32'h0, 64'h2, 2'd2, 1'b0);
    ifa.stall      = 2'b11;
    tick();
    idle();
    ifa.stall = 2'b10;
    #1;
    chk("wrap_oldest_ff", {55'd0, ifa.wb_uop[0].valid, ifa.wb_uop[0].sqn}, {55'd0, 1'b1, 8'hFF});
    chk("wrap_p1_stalled", 64'(ifa.wb_uop[1].valid), 64'd0);
    tick();
    idle();
    ifa.enq_uop[0] = mk(8'hFE, 1'b1, 1'b0, 32'h0, 64'h3, 2'd2, 1'b0);
    ifa.branch     = '{taken: 1'b1, sqn: 8'hFF};
    #1;
    chk("wrap_fe_issue", {55'd0, ifa.wb_uop[0].valid, ifa.wb_uop[0].sqn}, {55'd0, 1'b1, 8'hFE});
    chk("wrap_01_excluded", 64'(ifa.wb_uop[1].valid), 64'd0);
    tick();
    idle();
    #1;
    chk("wrap_empty", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);

    // Forward with partial mask, flags and doNotCommit pass-through
    u               = mk(8'd20, 1'b0, 1'b0, 32'h8004, 64'h1111_2222, 2'd2, 1'b0);
    u.fwd_mask      = 8'h03;
    u.exc           = AGU_PAGE_FAULT;
    u.do_not_commit = 1'b1;
    ifa.enq_uop[0]  = u;
    tick();
    idle();
    ifa.memc.ld_data_fwd = '{valid: 1'b1, addr: 32'h8000, data: line};
    #1;
    chk("fwd_not_same_cycle", 64'(ifa.wb_uop[0].valid), 64'd0);
    tick();
    idle();
    #1;
    chk("fwd_valid", 64'(ifa.wb_uop[0].valid), 64'd1);
    chk("fwd_result", ifa.wb_uop[0].result, 64'h1716_2222);
    chk("fwd_flags", 64'(ifa.wb_uop[0].flags), 64'(FLAGS_LD_PF));
    chk("fwd_dnc", 64'(ifa.wb_uop[0].do_not_commit), 64'd1);
    tick();

    // Full: three parked loads leave one slot, below NUM_IN
    ifa.enq_uop[0] = mk(8'd30, 1'b0, 1'b0, 32'h3000, 64'h0, 2'd2, 1'b0);
    ifa.enq_uop[1] = mk(8'd31, 1'b0, 1'b0, 32'h3004, 64'h0, 2'd2, 1'b0);
    tick();
    idle();
    #1;
    chk("full_two_ready", 64'(ifa.ready), 64'd1);
    ifa.enq_uop[0] = mk(8'd32, 1'b0, 1'b0, 32'h4000, 64'h0, 2'd2, 1'b0);
    tick();
    idle();
    #1;
    chk("full_not_ready", 64'(ifa.ready), 64'd0);
    ifa.memc.ld_data_fwd = '{valid: 1'b1, addr: 32'h4000, data: line};
    tick();
    idle();
    #1;
    chk("full_issue_32", {55'd0, ifa.wb_uop[0].valid, ifa.wb_uop[0].sqn}, {55'd0, 1'b1, 8'd32});
    chk("full_issue_res", ifa.wb_uop[0].result, 64'h1312_1110);
    chk("full_still_busy", 64'(ifa.ready), 64'd0);
    tick();
    #1;
    chk("full_ready_again", 64'(ifa.ready), 64'd1);
    ifa.branch = '{taken: 1'b1, sqn: 8'd29};
    tick();
    idle();
    #1;
    chk("cleanup_empty", 64'({ifa.wb_uop[1].valid, ifa.wb_uop[0].valid}), 64'd0);

    // XLEN=64: dword and sign-extended word
    ifb.enq_uop[0] = mk(8'd1, 1'b1, 1'b0, 32'h5000, 64'h8000_0000_0000_0001, 2'd3, 1'b1);
    ifb.enq_uop[1] = mk(8'd2, 1'b1, 1'b0, 32'h5004, 64'h8765_4321_0000_0000, 2'd2, 1'b1);
    #1;
    chk("x64_dword", ifb.wb_uop[0].result, 64'h8000_0000_0000_0001);
    chk("x64_word_sext", ifb.wb_uop[1].result, 64'hFFFF_FFFF_8765_4321);
    tick();
    idle();
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
